// File: rtl/ps2_device_tx_pkg.sv
// Shared PS/2 framing definitions: frame geometry, FSM encoding and frame-bit lookup.
package ps2_device_tx_pkg;

  localparam int FRAME_LEN = 11;
  localparam int IDX_W     = 4;

  localparam logic [IDX_W-1:0] IDX_PARITY = IDX_W'(FRAME_LEN - 2);
  localparam logic [IDX_W-1:0] IDX_STOP   = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLDOFF = 3'd1,
    ST_PH_HI   = 3'd2,
    ST_PH_LO   = 3'd3,
    ST_DONE    = 3'd4
  } tx_state_e;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Line level for frame position idx; data holds {parity, byte}.
  function automatic logic frame_bit(input logic [IDX_W-1:0] idx, input logic [8:0] data);
    logic b;
    b = 1'b1;
    if (idx == '0) begin
      b = 1'b0;
    end else if (idx <= IDX_PARITY) begin
      b = data[idx - 4'd1];
    end
    return b;
  endfunction

endpackage

// File: rtl/ps2_device_tx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit level.
module ps2_device_tx_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: serializes bytes into 11-bit frames on open-drain
// clock/data lines and restarts the whole frame whenever the host inhibits.
//
// state   | meaning
// IDLE    | ready for a byte
// HOLDOFF | waiting for the clock line to stay high INHIBIT_HOLD cycles
// PH_HI   | clock released, data bit driven
// PH_LO   | clock pulled low, data bit held
// DONE    | frame committed, one cycle before IDLE
module ps2_device_tx
  import ps2_device_tx_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int INHIBIT_HOLD = 1250
) (
  input  logic       i_clk25,
  input  logic       i_rst_n,
  input  logic [7:0] i_din,
  input  logic       i_din_valid,
  output logic       o_din_ready,
  input  logic       i_ps2_clk,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_din_oe,
  output logic       o_busy,
  output logic       o_aborted
);

  localparam int PH_W   = $clog2(CLK_DIV + 1);
  localparam int HOLD_W = $clog2(INHIBIT_HOLD + 1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(INHIBIT_HOLD - 1);

  tx_state_e          r_state;
  tx_state_e          w_state_nxt;
  logic [PH_W-1:0]    r_phase;
  logic [PH_W-1:0]    w_phase_nxt;
  logic [HOLD_W-1:0]  r_hold;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [8:0]         r_data;
  logic [8:0]         w_data_nxt;
  logic               r_clk_oe;
  logic               r_din_oe;
  logic               r_aborted;
  logic               w_abort;
  logic               w_clk_sync;
  logic               w_accept;
  logic               w_phase_last;

  ps2_device_tx_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync_clk (
    .i_clk   (i_clk25),
    .i_rst_n (i_rst_n),
    .i_async (i_ps2_clk),
    .o_sync  (w_clk_sync)
  );

  assign o_din_ready  = (r_state == ST_IDLE);
  assign o_busy       = ~o_din_ready;
  assign w_accept     = i_din_valid & o_din_ready;
  assign w_phase_last = (r_phase == PH_LAST);

  always_ff @(posedge i_clk25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_hold  <= '0;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_hold  <= w_hold_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_hold_nxt  = r_hold;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_abort     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_data_nxt  = {odd_parity(i_din), i_din};
          w_idx_nxt   = '0;
          w_hold_nxt  = '0;
          w_state_nxt = ST_HOLDOFF;
        end
      end

      ST_HOLDOFF: begin
        if (!w_clk_sync) begin
          w_hold_nxt = '0;
        end else if (r_hold == HOLD_LAST) begin
          w_hold_nxt  = '0;
          w_phase_nxt = '0;
          w_idx_nxt   = '0;
          w_state_nxt = ST_PH_HI;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end

      ST_PH_HI: begin
        if (w_phase_last) begin
          w_phase_nxt = '0;
          // Once the stop bit is on the wire the frame is committed.
          if (!w_clk_sync && (r_idx != IDX_STOP)) begin
            w_abort     = 1'b1;
            w_idx_nxt   = '0;
            w_hold_nxt  = '0;
            w_state_nxt = ST_HOLDOFF;
          end else begin
            w_state_nxt = ST_PH_LO;
          end
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end

      ST_PH_LO: begin
        if (w_phase_last) begin
          w_phase_nxt = '0;
          if (r_idx == IDX_STOP) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = ST_PH_HI;
          end
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Line drivers are registered from the next-state decode so the pads never glitch.
  always_ff @(posedge i_clk25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_oe  <= 1'b0;
      r_din_oe  <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_clk_oe  <= (w_state_nxt == ST_PH_LO);
      r_din_oe  <= ((w_state_nxt == ST_PH_HI) || (w_state_nxt == ST_PH_LO)) &&
                   !frame_bit(w_idx_nxt, w_data_nxt);
      r_aborted <= w_abort;
    end
  end

  assign o_ps2_clk_oe = r_clk_oe;
  assign o_ps2_din_oe = r_din_oe;
  assign o_aborted    = r_aborted;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: a line monitor decodes frames at each clock falling edge
// and compares them with frames built arithmetically from the bytes sent.
module tb_ps2_device_tx;

  localparam int CLK_DIV      = 4;
  localparam int INHIBIT_HOLD = 8;
  localparam int SYNC_LAT     = 2;
  localparam int FRAME_CYC    = 1 + INHIBIT_HOLD + 22 * CLK_DIV;

  logic       clk25 = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       ps2_clk_i;
  logic       ps2_clk_oe;
  logic       ps2_din_oe;
  logic       busy;
  logic       aborted;
  logic       hold_low = 1'b0;

  always #20 clk25 = ~clk25;

  assign ps2_clk_i = ~ps2_clk_oe & ~hold_low;

  ps2_device_tx #(
    .CLK_DIV      (CLK_DIV),
    .INHIBIT_HOLD (INHIBIT_HOLD)
  ) dut (
    .i_clk25      (clk25),
    .i_rst_n      (rst_n),
    .i_din        (din),
    .i_din_valid  (din_valid),
    .o_din_ready  (din_ready),
    .i_ps2_clk    (ps2_clk_i),
    .o_ps2_clk_oe (ps2_clk_oe),
    .o_ps2_din_oe (ps2_din_oe),
    .o_busy       (busy),
    .o_aborted    (aborted)
  );

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  // Host-side monitor: sample data on each clock falling edge (oe rising).
  int          bit_k = 0;
  int          abort_cnt = 0;
  logic        prev_oe = 1'b0;
  logic [10:0] shreg = '0;
  logic [10:0] rx_q[$];

  always @(negedge clk25) begin
    if (!rst_n) begin
      bit_k   = 0;
      prev_oe = 1'b0;
    end else begin
      if (aborted) begin
        bit_k = 0;
        abort_cnt++;
      end
      if (ps2_clk_oe && !prev_oe) begin
        shreg[bit_k] = ~ps2_din_oe;
        bit_k++;
        if (bit_k == 11) begin
          rx_q.push_back(shreg);
          bit_k = 0;
        end
      end
      prev_oe = ps2_clk_oe;
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int acc_cyc = 0;

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    int par;
    par = ($countones(b) % 2 == 0) ? 1 : 0;
    return 11'(1024 + par * 512 + int'(b) * 2);
  endfunction

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    din = b;
    din_valid = 1'b1;
    while (!din_ready && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("accept_timeout", 32'(din_ready), 32'd1);
    tick();
    acc_cyc = cyc;
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!din_ready && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, 32'(din_ready), 32'd1);
  endtask

  task automatic wait_bits(input int k, input logic oe_level);
    int n;
    n = 0;
    while (!(bit_k == k && ps2_clk_oe == oe_level) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("bit_wait_timeout", 32'(bit_k), 32'(k));
  endtask

  task automatic check_frame(input string tag, input logic [10:0] exp);
    logic [10:0] f;
    chk({tag, "_count"}, 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) begin
      f = rx_q.pop_front();
      chk(tag, 32'(f), 32'(exp));
    end
  endtask

  task automatic measure_first_edge(input string tag);
    int rel;
    int n;
    hold_low = 1'b0;
    rel = cyc;
    n = 0;
    while (!ps2_clk_oe && n < 200) begin
      tick();
      n++;
    end
    // The release must cross the synchronizer before the holdoff count starts.
    chk(tag, 32'(cyc - rel), 32'(SYNC_LAT + INHIBIT_HOLD + CLK_DIV));
  endtask

  initial begin
    logic [7:0] b;
    int t0;
    int t1;
    int n;
    logic seen;

    #50;
    chk("rst_din_ready", 32'(din_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_din_oe", 32'(ps2_din_oe), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    send(8'h1C);
    t0 = acc_cyc;
    chk("ready_falls", 32'(din_ready), 32'd0);
    chk("busy_complement", 32'(busy), 32'd1);
    wait_idle("basic_done");
    chk("basic_latency", 32'(cyc - t0), 32'(FRAME_CYC));
    chk("basic_busy_clear", 32'(busy), 32'd0);
    check_frame("basic_frame", 11'h438);

    send(8'h00);
    wait_idle("zero_done");
    check_frame("zero_frame", 11'h600);

    b = 8'($urandom);
    send(b);
    wait_bits(4, 1'b0);
    hold_low = 1'b1;
    n = 0;
    while (!aborted && n < 20) begin
      tick();
      n++;
    end
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_clk_released", 32'(ps2_clk_oe), 32'd0);
    chk("abort_din_released", 32'(ps2_din_oe), 32'd0);
    chk("abort_keeps_byte", 32'(busy), 32'd1);
    tick();
    chk("abort_one_cycle", 32'(aborted), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (ps2_clk_oe) seen = 1'b1;
    end
    chk("inhibit_quiet", 32'(seen), 32'd0);
    measure_first_edge("retry_first_edge");
    wait_idle("retry_done");
    check_frame("retry_frame", exp_frame(b));
    chk("abort_count", 32'(abort_cnt), 32'd1);

    din = 8'h1C;
    din_valid = 1'b1;
    tick();
    t0 = cyc;
    din = 8'hF0;
    n = 0;
    while (!din_ready && n < 2000) begin
      tick();
      n++;
    end
    tick();
    t1 = cyc;
    din_valid = 1'b0;
    chk("bp_second_accept", 32'(t1 - t0), 32'(FRAME_CYC + 1));
    chk("bp_second_busy", 32'(busy), 32'd1);
    wait_idle("bp_done");
    chk("bp_frame_count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      chk("bp_frame0", 32'(rx_q[0]), 32'h438);
      chk("bp_frame1", 32'(rx_q[1]), 32'h7E0);
    end
    rx_q.delete();

    hold_low = 1'b1;
    b = 8'($urandom);
    send(b);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (ps2_clk_oe || din_ready) seen = 1'b1;
    end
    chk("holdoff_quiet", 32'(seen), 32'd0);
    measure_first_edge("holdoff_first_edge");
    wait_idle("holdoff_done");
    check_frame("holdoff_frame", exp_frame(b));

    send(8'h5A);
    wait_bits(7, 1'b1);
    chk("pre_rst_clk_oe", 32'(ps2_clk_oe), 32'd1);
    chk("pre_rst_din_oe", 32'(ps2_din_oe), 32'd1);
    #5;
    rst_n = 1'b0;
    #1;
    chk("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("midrst_din_oe", 32'(ps2_din_oe), 32'd0);
    chk("midrst_din_ready", 32'(din_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_no_frame", 32'(rx_q.size()), 32'd0);
    b = 8'($urandom);
    send(b);
    wait_idle("post_rst_done");
    check_frame("post_rst_frame", exp_frame(b));

    repeat (6) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 5)) tick();
      send(b);
      wait_idle("rand_done");
      check_frame("rand_frame", exp_frame(b));
    end
    chk("final_abort_count", 32'(abort_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
